// File: rtl/mips_isa_pkg.sv
// MIPS32 instruction ids (decoder one-hot bit positions) and per-id encoding info
// used to turn a one-hot request back into a 32-bit instruction word.
package mips_isa_pkg;

    localparam int unsigned NUM_INS = 54;

    localparam logic [5:0] ID_ADD     = 6'd0;
    localparam logic [5:0] ID_ADDI    = 6'd1;
    localparam logic [5:0] ID_ADDU    = 6'd2;
    localparam logic [5:0] ID_ADDIU   = 6'd3;
    localparam logic [5:0] ID_SUB     = 6'd4;
    localparam logic [5:0] ID_SUBU    = 6'd5;
    localparam logic [5:0] ID_AND     = 6'd6;
    localparam logic [5:0] ID_ANDI    = 6'd7;
    localparam logic [5:0] ID_J       = 6'd8;
    localparam logic [5:0] ID_JAL     = 6'd9;
    localparam logic [5:0] ID_OR      = 6'd10;
    localparam logic [5:0] ID_ORI     = 6'd11;
    localparam logic [5:0] ID_XOR     = 6'd12;
    localparam logic [5:0] ID_XORI    = 6'd13;
    localparam logic [5:0] ID_NOR     = 6'd14;
    localparam logic [5:0] ID_LUI     = 6'd15;
    localparam logic [5:0] ID_SLL     = 6'd16;
    localparam logic [5:0] ID_SRL     = 6'd17;
    localparam logic [5:0] ID_SRA     = 6'd18;
    localparam logic [5:0] ID_SLLV    = 6'd19;
    localparam logic [5:0] ID_SRLV    = 6'd20;
    localparam logic [5:0] ID_SRAV    = 6'd21;
    localparam logic [5:0] ID_SLT     = 6'd22;
    localparam logic [5:0] ID_SLTI    = 6'd23;
    localparam logic [5:0] ID_SLTU    = 6'd24;
    localparam logic [5:0] ID_SLTIU   = 6'd25;
    localparam logic [5:0] ID_BEQ     = 6'd26;
    localparam logic [5:0] ID_BNE     = 6'd27;
    localparam logic [5:0] ID_BGEZ    = 6'd28;
    localparam logic [5:0] ID_JR      = 6'd29;
    localparam logic [5:0] ID_JALR    = 6'd30;
    localparam logic [5:0] ID_LW      = 6'd31;
    localparam logic [5:0] ID_SW      = 6'd32;
    localparam logic [5:0] ID_ERET    = 6'd33;
    localparam logic [5:0] ID_LB      = 6'd34;
    localparam logic [5:0] ID_LBU     = 6'd35;
    localparam logic [5:0] ID_LH      = 6'd36;
    localparam logic [5:0] ID_LHU     = 6'd37;
    localparam logic [5:0] ID_SB      = 6'd38;
    localparam logic [5:0] ID_SH      = 6'd39;
    localparam logic [5:0] ID_MFHI    = 6'd40;
    localparam logic [5:0] ID_MFLO    = 6'd41;
    localparam logic [5:0] ID_MTHI    = 6'd42;
    localparam logic [5:0] ID_MTLO    = 6'd43;
    localparam logic [5:0] ID_DIV     = 6'd44;
    localparam logic [5:0] ID_DIVU    = 6'd45;
    localparam logic [5:0] ID_MULTU   = 6'd46;
    localparam logic [5:0] ID_TEQ     = 6'd47;
    localparam logic [5:0] ID_SYSCALL = 6'd48;
    localparam logic [5:0] ID_BREAK   = 6'd49;
    localparam logic [5:0] ID_MFC0    = 6'd50;
    localparam logic [5:0] ID_MUL     = 6'd51;
    localparam logic [5:0] ID_MTC0    = 6'd52;
    localparam logic [5:0] ID_CLZ     = 6'd53;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_FIX} fmt_e;

    // Field usage mask bits: {rs, rt, rd, shamt, rd copied into rt slot}
    localparam logic [4:0] M_NONE = 5'b00000;
    localparam logic [4:0] M_RS   = 5'b10000;
    localparam logic [4:0] M_RT   = 5'b01000;
    localparam logic [4:0] M_RD   = 5'b00100;
    localparam logic [4:0] M_SH   = 5'b00010;
    localparam logic [4:0] M_RDRT = 5'b00001;
    localparam logic [4:0] M_RRR  = M_RS | M_RT | M_RD;

    typedef struct packed {
        fmt_e        fmt;
        logic [31:0] base;
        logic        use_rs;
        logic        use_rt;
        logic        use_rd;
        logic        use_sh;
        logic        rd_to_rt;
    } enc_info_t;

    function automatic enc_info_t mk(input fmt_e fmt, input logic [31:0] base,
                                     input logic [4:0] mask);
        enc_info_t info;
        info.fmt  = fmt;
        info.base = base;
        {info.use_rs, info.use_rt, info.use_rd, info.use_sh, info.rd_to_rt} = mask;
        return info;
    endfunction

    function automatic logic [31:0] op(input logic [5:0] opcode);
        return {opcode, 26'b0};
    endfunction

    function automatic logic [31:0] fn(input logic [5:0] func);
        return {26'b0, func};
    endfunction

    function automatic enc_info_t ins_info(input logic [5:0] id);
        enc_info_t info;
        case (id)
            ID_ADD:     info = mk(FMT_R, fn(6'h20), M_RRR);
            ID_ADDU:    info = mk(FMT_R, fn(6'h21), M_RRR);
            ID_SUB:     info = mk(FMT_R, fn(6'h22), M_RRR);
            ID_SUBU:    info = mk(FMT_R, fn(6'h23), M_RRR);
            ID_AND:     info = mk(FMT_R, fn(6'h24), M_RRR);
            ID_OR:      info = mk(FMT_R, fn(6'h25), M_RRR);
            ID_XOR:     info = mk(FMT_R, fn(6'h26), M_RRR);
            ID_NOR:     info = mk(FMT_R, fn(6'h27), M_RRR);
            ID_SLT:     info = mk(FMT_R, fn(6'h2A), M_RRR);
            ID_SLTU:    info = mk(FMT_R, fn(6'h2B), M_RRR);
            ID_SLLV:    info = mk(FMT_R, fn(6'h04), M_RRR);
            ID_SRLV:    info = mk(FMT_R, fn(6'h06), M_RRR);
            ID_SRAV:    info = mk(FMT_R, fn(6'h07), M_RRR);
            ID_SLL:     info = mk(FMT_R, fn(6'h00), M_RT | M_RD | M_SH);
            ID_SRL:     info = mk(FMT_R, fn(6'h02), M_RT | M_RD | M_SH);
            ID_SRA:     info = mk(FMT_R, fn(6'h03), M_RT | M_RD | M_SH);
            ID_JR:      info = mk(FMT_R, fn(6'h08), M_RS);
            ID_JALR:    info = mk(FMT_R, fn(6'h09), M_RS | M_RD);
            ID_MFHI:    info = mk(FMT_R, fn(6'h10), M_RD);
            ID_MTHI:    info = mk(FMT_R, fn(6'h11), M_RS);
            ID_MFLO:    info = mk(FMT_R, fn(6'h12), M_RD);
            ID_MTLO:    info = mk(FMT_R, fn(6'h13), M_RS);
            ID_MULTU:   info = mk(FMT_R, fn(6'h19), M_RS | M_RT);
            ID_DIV:     info = mk(FMT_R, fn(6'h1A), M_RS | M_RT);
            ID_DIVU:    info = mk(FMT_R, fn(6'h1B), M_RS | M_RT);
            ID_TEQ:     info = mk(FMT_R, fn(6'h34), M_RS | M_RT);
            ID_SYSCALL: info = mk(FMT_R, fn(6'h0C), M_NONE);
            ID_BREAK:   info = mk(FMT_R, fn(6'h0D), M_NONE);
            ID_ADDI:    info = mk(FMT_I, op(6'h08), M_RS | M_RT);
            ID_ADDIU:   info = mk(FMT_I, op(6'h09), M_RS | M_RT);
            ID_SLTI:    info = mk(FMT_I, op(6'h0A), M_RS | M_RT);
            ID_SLTIU:   info = mk(FMT_I, op(6'h0B), M_RS | M_RT);
            ID_ANDI:    info = mk(FMT_I, op(6'h0C), M_RS | M_RT);
            ID_ORI:     info = mk(FMT_I, op(6'h0D), M_RS | M_RT);
            ID_XORI:    info = mk(FMT_I, op(6'h0E), M_RS | M_RT);
            ID_LUI:     info = mk(FMT_I, op(6'h0F), M_RT);
            ID_BEQ:     info = mk(FMT_I, op(6'h04), M_RS | M_RT);
            ID_BNE:     info = mk(FMT_I, op(6'h05), M_RS | M_RT);
            ID_BGEZ:    info = mk(FMT_I, 32'h0401_0000, M_RS);
            ID_LB:      info = mk(FMT_I, op(6'h20), M_RS | M_RT);
            ID_LH:      info = mk(FMT_I, op(6'h21), M_RS | M_RT);
            ID_LW:      info = mk(FMT_I, op(6'h23), M_RS | M_RT);
            ID_LBU:     info = mk(FMT_I, op(6'h24), M_RS | M_RT);
            ID_LHU:     info = mk(FMT_I, op(6'h25), M_RS | M_RT);
            ID_SB:      info = mk(FMT_I, op(6'h28), M_RS | M_RT);
            ID_SH:      info = mk(FMT_I, op(6'h29), M_RS | M_RT);
            ID_SW:      info = mk(FMT_I, op(6'h2B), M_RS | M_RT);
            ID_J:       info = mk(FMT_J, op(6'h02), M_NONE);
            ID_JAL:     info = mk(FMT_J, op(6'h03), M_NONE);
            ID_MFC0:    info = mk(FMT_FIX, 32'h4000_0000, M_RT | M_RD);
            ID_MTC0:    info = mk(FMT_FIX, 32'h4080_0000, M_RT | M_RD);
            ID_ERET:    info = mk(FMT_FIX, 32'h4200_0018, M_NONE);
            ID_CLZ:     info = mk(FMT_FIX, 32'h7000_0020, M_RS | M_RD | M_RDRT);
            ID_MUL:     info = mk(FMT_FIX, 32'h7000_0002, M_RRR);
            default:    info = mk(FMT_FIX, 32'h0, M_NONE);
        endcase
        return info;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty come from the registered count, so a pop never
// frees a slot for a push in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs one-hot instruction requests into MIPS32 words, queues them, and streams
// them into IMEM at a self-incrementing (or reloadable) word address.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AW        = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [53:0]   i_ins,
    input  logic [4:0]    i_rs,
    input  logic [4:0]    i_rt,
    input  logic [4:0]    i_rd,
    input  logic [4:0]    i_shamt,
    input  logic [15:0]   i_imm,
    input  logic [25:0]   i_target,
    input  logic          i_addr_load,
    input  logic [AW-1:0] i_addr_in,
    output logic          o_mem_we,
    input  logic          i_mem_ready,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic          o_err_illegal,
    output logic [7:0]    o_err_cnt,
    output logic          o_busy
);
    logic          w_onehot;
    logic [5:0]    w_id;
    enc_info_t     w_info;
    logic [31:0]   w_word;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] r_addr;
    logic          r_err_illegal;
    logic [7:0]    r_err_cnt;

    // x & (x-1) clears the lowest set bit; zero result with x != 0 means one-hot
    assign w_onehot = (i_ins != '0) && ((i_ins & (i_ins - 54'd1)) == '0);

    always_comb begin
        w_id = '0;
        for (int i = 0; i < int'(NUM_INS); i++) begin
            if (i_ins[i]) begin
                w_id = 6'(i);
            end
        end
    end

    assign w_info = ins_info(w_id);

    always_comb begin
        w_word = w_info.base;
        if (w_info.use_rs)   w_word = w_word | {6'b0, i_rs, 21'b0};
        if (w_info.use_rt)   w_word = w_word | {11'b0, i_rt, 16'b0};
        if (w_info.rd_to_rt) w_word = w_word | {11'b0, i_rd, 16'b0};
        if (w_info.use_rd)   w_word = w_word | {16'b0, i_rd, 11'b0};
        if (w_info.use_sh)   w_word = w_word | {21'b0, i_shamt, 6'b0};
        if (w_info.fmt == FMT_I) w_word = w_word | {16'b0, i_imm};
        if (w_info.fmt == FMT_J) w_word = w_word | {6'b0, i_target};
    end

    assign o_in_ready = !w_full;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_push     = w_accept && w_onehot;
    assign o_mem_we   = !w_empty;
    assign o_busy     = !w_empty;
    assign w_pop      = o_mem_we && i_mem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (o_mem_wdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= AW'(BASE_ADDR);
            r_err_illegal <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            if (i_addr_load) begin
                r_addr <= i_addr_in;
            end else if (w_pop) begin
                r_addr <= r_addr + AW'(1);
            end
            r_err_illegal <= w_accept && !w_onehot;
            if (w_accept && !w_onehot && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_mem_addr    = r_addr;
    assign o_err_illegal = r_err_illegal;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, FIFO backpressure, illegal
// requests, address reload/wrap and asynchronous reset.
module tb_instr_encoder_loader;
    import mips_isa_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [53:0] ins;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        addr_load;
    logic [9:0]  addr_in;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        err_illegal;
    logic [7:0]  err_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    instr_encoder_loader #(
        .DEPTH     (4),
        .AW        (10),
        .BASE_ADDR (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_ins         (ins),
        .i_rs          (rs),
        .i_rt          (rt),
        .i_rd          (rd),
        .i_shamt       (shamt),
        .i_imm         (imm),
        .i_target      (target),
        .i_addr_load   (addr_load),
        .i_addr_in     (addr_in),
        .o_mem_we      (mem_we),
        .i_mem_ready   (mem_ready),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_err_illegal (err_illegal),
        .o_err_cnt     (err_cnt),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed encodings: MUL, CLZ, BGEZ, MTC0, LUI
    logic [5:0]  t_id  [5];
    logic [4:0]  t_rs  [5];
    logic [4:0]  t_rt  [5];
    logic [4:0]  t_rd  [5];
    logic [15:0] t_imm [5];
    logic [31:0] t_exp [5];
    logic [31:0] full_exp [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [4:0] a_rs, input logic [4:0] a_rt,
                           input logic [4:0] a_rd, input logic [4:0] a_sh,
                           input logic [15:0] a_imm, input logic [25:0] a_tgt);
        ins     = '0;
        ins[id] = 1'b1;
        rs      = a_rs;
        rt      = a_rt;
        rd      = a_rd;
        shamt   = a_sh;
        imm     = a_imm;
        target  = a_tgt;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        addr_load = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t_id[0] = 6'd51;   t_rs[0] = 5'd1; t_rt[0] = 5'd2; t_rd[0] = 5'd3;  t_imm[0] = 16'h0;
        t_exp[0] = 32'h7022_1802;
        t_id[1] = 6'd53;   t_rs[1] = 5'd3; t_rt[1] = 5'd9; t_rd[1] = 5'd7;  t_imm[1] = 16'h0;
        t_exp[1] = 32'h7067_3820;
        t_id[2] = ID_BGEZ; t_rs[2] = 5'd4; t_rt[2] = 5'd9; t_rd[2] = 5'd0;  t_imm[2] = 16'h0010;
        t_exp[2] = 32'h0481_0010;
        t_id[3] = ID_MTC0; t_rs[3] = 5'd6; t_rt[3] = 5'd8; t_rd[3] = 5'd12; t_imm[3] = 16'h0;
        t_exp[3] = 32'h4088_6000;
        t_id[4] = ID_LUI;  t_rs[4] = 5'd5; t_rt[4] = 5'd3; t_rd[4] = 5'd0;  t_imm[4] = 16'h1234;
        t_exp[4] = 32'h3C03_1234;
        full_exp[0] = 32'h0022_0020;
        full_exp[1] = 32'h0022_0820;
        full_exp[2] = 32'h0022_1020;
        full_exp[3] = 32'h0022_1820;

        rst_n = 1'b0; in_valid = 1'b0; ins = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
        imm = '0; target = '0; addr_load = 1'b0; addr_in = '0; mem_ready = 1'b0;
        repeat (2) step();
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_err_illegal", err_illegal, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // ADD: one-cycle latency to the write port
        mem_ready = 1'b1;
        set_req(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("add_we", mem_we, 1);
        chk("add_data", mem_wdata, 32'h0022_1820);
        chk("add_addr", mem_addr, 0);
        step();
        chk("add_done_we", mem_we, 0);
        chk("add_done_addr", mem_addr, 1);

        // ADDI, SLL (rs forced 0), J, ERET, then table, one per cycle
        do_reset();
        set_req(1, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0);
        in_valid = 1'b1;
        step();
        chk("addi_data", mem_wdata, 32'h2022_0005);
        chk("addi_addr", mem_addr, 0);
        set_req(16, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0);
        step();
        chk("sll_data", mem_wdata, 32'h0005_2080);
        chk("sll_addr", mem_addr, 1);
        set_req(8, 5'd3, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h010_0000);
        step();
        chk("j_data", mem_wdata, 32'h0810_0000);
        chk("j_addr", mem_addr, 2);
        set_req(33, 5'd31, 5'd17, 5'd9, 5'd3, 16'hBEEF, 26'h3FF_FFFF);
        step();
        chk("eret_data", mem_wdata, 32'h4200_0018);
        chk("eret_addr", mem_addr, 3);
        for (int k = 0; k < 5; k++) begin
            set_req(int'(t_id[k]), t_rs[k], t_rt[k], t_rd[k], 5'd5, t_imm[k], 26'h155_5555);
            step();
            chk($sformatf("tbl%0d_we", k), mem_we, 1);
            chk($sformatf("tbl%0d_data", k), mem_wdata, t_exp[k]);
            chk($sformatf("tbl%0d_addr", k), mem_addr, 32'(4 + k));
        end
        in_valid = 1'b0;
        step();
        chk("stream_done_we", mem_we, 0);
        chk("stream_done_addr", mem_addr, 9);

        // Backpressure: six back-to-back requests, only four fit
        do_reset();
        mem_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 5'd1, 5'd2, 5'(k), 5'd0, 16'h0, 26'h0);
            step();
            chk($sformatf("full%0d_in_ready", k), in_ready, (k < 3) ? 1 : 0);
            chk($sformatf("full%0d_head", k), mem_wdata, full_exp[0]);
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_we", i), mem_we, 1);
            chk($sformatf("drain%0d_data", i), mem_wdata, full_exp[i]);
            chk($sformatf("drain%0d_addr", i), mem_addr, 32'(i));
            step();
        end
        chk("drain_done_we", mem_we, 0);
        chk("drain_done_busy", busy, 0);
        chk("drain_done_addr", mem_addr, 4);

        // Illegal requests: zero bits, then two bits
        ins = '0;
        in_valid = 1'b1;
        step();
        chk("ill0_pulse", err_illegal, 1);
        chk("ill0_cnt", err_cnt, 1);
        chk("ill0_we", mem_we, 0);
        ins = 54'd3;
        step();
        chk("ill1_pulse", err_illegal, 1);
        chk("ill1_cnt", err_cnt, 2);
        in_valid = 1'b0;
        step();
        chk("ill_pulse_low", err_illegal, 0);
        chk("ill_cnt_hold", err_cnt, 2);
        chk("ill_addr", mem_addr, 4);
        chk("ill_busy", busy, 0);
        ins = '0;
        in_valid = 1'b1;
        repeat (260) step();
        in_valid = 1'b0;
        chk("ill_sat", err_cnt, 255);

        // Address reload to the top of the space, then wrap to 0
        mem_ready = 1'b0;
        addr_load = 1'b1;
        addr_in   = 10'd1023;
        set_req(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        addr_load = 1'b0;
        chk("load_addr", mem_addr, 1023);
        set_req(1, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0);
        step();
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        chk("wrap0_data", mem_wdata, 32'h0022_1820);
        chk("wrap0_addr", mem_addr, 1023);
        step();
        chk("wrap1_data", mem_wdata, 32'h2022_0005);
        chk("wrap1_addr", mem_addr, 0);
        step();
        chk("wrap_done_we", mem_we, 0);
        chk("wrap_done_addr", mem_addr, 1);

        // Load beats increment when a write completes in the same cycle
        mem_ready = 1'b0;
        set_req(16, 5'd0, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        addr_load = 1'b1;
        addr_in   = 10'd10;
        chk("ldwr_old_addr", mem_addr, 1);
        chk("ldwr_we", mem_we, 1);
        step();
        addr_load = 1'b0;
        chk("ldwr_new_addr", mem_addr, 10);
        chk("ldwr_done_we", mem_we, 0);

        // Asynchronous reset with words queued
        mem_ready = 1'b0;
        set_req(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_err_cnt", err_cnt, 0);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        step();
        chk("post_rst_we", mem_we, 0);
        chk("post_rst_addr", mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
